// File: rtl/ring_meter.sv
`default_nettype none
// ============================================================================
// Module   : ring_meter
// Brief    : Gated edge counter that measures the frequency of an asynchronous
//            ring-oscillator signal and exposes the result one byte at a time.
// Revision : 1.0
// ============================================================================
module ring_meter #(
    parameter int pGATE_LOG2 = 10,
    parameter int pWIDTH     = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ring,
    input  logic        i_start,
    input  logic        i_byte_sel,
    output logic        o_busy,
    output logic        o_valid,
    output logic        o_ovf,
    output logic [15:0] o_count,
    output logic [7:0]  o_data
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ARM  = 2'd1;
    localparam logic [1:0] c_ST_GATE = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [1:0]          c_ARM_LAST  = 2'd2;
    localparam logic [pGATE_LOG2:0] c_GATE_LAST = {1'b0, {pGATE_LOG2{1'b1}}};
    localparam logic [pGATE_LOG2:0] c_GATE_ONE  = {{pGATE_LOG2{1'b0}}, 1'b1};
    localparam logic [pWIDTH-1:0]   c_EDGE_MAX  = {pWIDTH{1'b1}};
    localparam logic [pWIDTH-1:0]   c_EDGE_ONE  = {{(pWIDTH-1){1'b0}}, 1'b1};

    logic                  r_s1;
    logic                  r_s2;
    logic                  r_s3;
    logic [1:0]            r_state;
    logic [1:0]            r_arm_cnt;
    logic [pGATE_LOG2:0]   r_gate_cnt;
    logic [pWIDTH-1:0]     r_edge_cnt;
    logic                  r_ovf_int;
    logic                  r_ovf;
    logic [15:0]           r_count;

    logic                  w_edge;
    logic                  w_edge_sat;
    logic [pWIDTH-1:0]     w_edge_next;
    logic                  w_ovf_next;
    logic [15:0]           w_count_ext;

    assign w_edge      = r_s2 & ~r_s3;
    assign w_edge_sat  = (r_edge_cnt == c_EDGE_MAX);
    assign w_edge_next = (w_edge && !w_edge_sat) ? (r_edge_cnt + c_EDGE_ONE) : r_edge_cnt;
    assign w_ovf_next  = r_ovf_int | (w_edge & w_edge_sat);

    generate
        if (pWIDTH < 16) begin : g_zext
            assign w_count_ext = {{(16-pWIDTH){1'b0}}, w_edge_next};
        end else begin : g_full
            assign w_count_ext = w_edge_next;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_state    <= c_ST_IDLE;
            r_arm_cnt  <= 2'd0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_int  <= 1'b0;
            r_ovf      <= 1'b0;
            r_count    <= 16'd0;
        end else begin
            r_s1 <= i_ring;
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (i_start) begin
                        r_state    <= c_ST_ARM;
                        r_arm_cnt  <= 2'd0;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_int  <= 1'b0;
                    end
                end
                // Synchronizer flush; events seen here are stale and dropped.
                c_ST_ARM: begin
                    if (r_arm_cnt == c_ARM_LAST) begin
                        r_state <= c_ST_GATE;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 2'd1;
                    end
                end
                c_ST_GATE: begin
                    r_edge_cnt <= w_edge_next;
                    r_ovf_int  <= w_ovf_next;
                    if (r_gate_cnt == c_GATE_LAST) begin
                        r_count <= w_count_ext;
                        r_ovf   <= w_ovf_next;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + c_GATE_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy  = (r_state == c_ST_ARM) || (r_state == c_ST_GATE);
    assign o_valid = (r_state == c_ST_DONE);
    assign o_ovf   = r_ovf;
    assign o_count = r_count;
    assign o_data  = i_byte_sel ? r_count[15:8] : r_count[7:0];

endmodule
`default_nettype wire

// File: tb/tb_ring_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_meter
// Brief    : Randomized self-checking bench for ring_meter with a history-based
//            edge-count reference model (three parameterisations).
// Revision : 1.0
// ============================================================================
module tb_ring_meter;

    localparam int c_NLOG0 = 10;
    localparam int c_NLOG1 = 10;
    localparam int c_NLOG2 = 16;
    localparam int c_W0    = 16;
    localparam int c_W1    = 8;
    localparam int c_HIST  = 131072;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, rst2;
    logic        ring0, ring1, ring2;
    logic        start0, start1, start2;
    logic        sel0, sel1, sel2;
    logic        busy0, busy1, busy2;
    logic        valid0, valid1, valid2;
    logic        ovf0, ovf1, ovf2;
    logic [15:0] cnt0, cnt1, cnt2;
    logic [7:0]  data0, data1, data2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mode0   = 0;
    int per0    = 8;
    bit big_done = 1'b0;
    int ps_last;

    bit h0 [0:c_HIST-1];
    bit h1 [0:c_HIST-1];
    bit h2 [0:c_HIST-1];

    ring_meter #(.pGATE_LOG2(c_NLOG0), .pWIDTH(c_W0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst0), .i_ring(ring0), .i_start(start0), .i_byte_sel(sel0),
        .o_busy(busy0), .o_valid(valid0), .o_ovf(ovf0), .o_count(cnt0), .o_data(data0));

    ring_meter #(.pGATE_LOG2(c_NLOG1), .pWIDTH(c_W1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst1), .i_ring(ring1), .i_start(start1), .i_byte_sel(sel1),
        .o_busy(busy1), .o_valid(valid1), .o_ovf(ovf1), .o_count(cnt1), .o_data(data1));

    ring_meter #(.pGATE_LOG2(c_NLOG2), .pWIDTH(16)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst2), .i_ring(ring2), .i_start(start2), .i_byte_sel(sel2),
        .o_busy(busy2), .o_valid(valid2), .o_ovf(ovf2), .o_count(cnt2), .o_data(data2));

    // Ring sources change on the falling edge so each rising edge samples a settled level.
    initial begin
        int c0, c1, c2, d0;
        c0 = 0; c1 = 0; c2 = 0; d0 = 2;
        ring0 = 1'b0; ring1 = 1'b0; ring2 = 1'b0;
        forever begin
            @(negedge clk);
            case (mode0)
                0: begin ring0 = 1'b0; c0 = 0; end
                1: begin ring0 = 1'b1; c0 = 0; end
                2: begin
                    c0++;
                    if (c0 >= per0 / 2) begin c0 = 0; ring0 = ~ring0; end
                end
                default: begin
                    c0++;
                    if (c0 >= d0) begin
                        c0 = 0; ring0 = ~ring0; d0 = int'($urandom_range(2, 6));
                    end
                end
            endcase
            c1++;
            if (c1 >= 2) begin c1 = 0; ring1 = ~ring1; end
            c2++;
            if (c2 >= 7) begin c2 = 0; ring2 = ~ring2; end
        end
    end

    always @(posedge clk) begin
        if (cyc < c_HIST) begin
            h0[cyc] <= ring0;
            h1[cyc] <= ring1;
            h2[cyc] <= ring2;
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic bit hv(input int id, input int k);
        case (id)
            0:       return h0[k];
            1:       return h1[k];
            default: return h2[k];
        endcase
    endfunction

    // A rising edge sampled at cycles k-1 -> k is counted when it shows up three
    // edges later inside the N-cycle gate window that starts 3 cycles after start.
    function automatic int model_edges(input int id, input int ps, input int nlog);
        int c;
        c = 0;
        for (int m = ps + 3; m <= ps + 2 + (1 << nlog); m++) begin
            if (hv(id, m - 1) && !hv(id, m - 2)) c++;
        end
        return c;
    endfunction

    function automatic logic busy_of(input int id);
        return (id == 0) ? busy0 : busy1;
    endfunction

    function automatic logic valid_of(input int id);
        return (id == 0) ? valid0 : valid1;
    endfunction

    function automatic logic [15:0] cnt_of(input int id);
        return (id == 0) ? cnt0 : cnt1;
    endfunction

    function automatic logic ovf_of(input int id);
        return (id == 0) ? ovf0 : ovf1;
    endfunction

    task automatic kick(input int id);
        @(negedge clk);
        if (id == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ps_last = cyc - 1;
        if (id == 0) start0 = 1'b0; else start1 = 1'b0;
    endtask

    task automatic wait_done(input int id, input int nlog, input string tag);
        int nb;
        nb = 0;
        for (int i = 0; i < (1 << nlog) + 20; i++) begin
            if (!busy_of(id)) break;
            nb++;
            @(negedge clk);
        end
        chk({tag, "_busylen"}, nb, (1 << nlog) + 3);
        chk({tag, "_valid"}, valid_of(id), 1);
    endtask

    task automatic chk_result(input int id, input int ps, input int nlog, input int w,
                              input string tag);
        int e, mx;
        e  = model_edges(id, ps, nlog);
        mx = (1 << w) - 1;
        chk({tag, "_cnt"}, cnt_of(id), (e > mx) ? mx : e);
        chk({tag, "_ovf"}, ovf_of(id), (e > mx) ? 1 : 0);
    endtask

    task automatic chk_zero(input int id, input string tag);
        if (id == 0) begin
            chk({tag, "_busy"}, busy0, 0);
            chk({tag, "_valid"}, valid0, 0);
            chk({tag, "_ovf"}, ovf0, 0);
            chk({tag, "_cnt"}, cnt0, 0);
            chk({tag, "_data"}, data0, 0);
        end else begin
            chk({tag, "_busy"}, busy1, 0);
            chk({tag, "_valid"}, valid1, 0);
            chk({tag, "_cnt"}, cnt1, 0);
        end
    endtask

    initial begin : big
        int ps2, nb2, e2;
        start2 = 1'b0; sel2 = 1'b0; rst2 = 1'b0;
        repeat (3) @(negedge clk);
        rst2 = 1'b1;
        repeat (20) @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ps2 = cyc - 1;
        start2 = 1'b0;
        nb2 = 0;
        for (int i = 0; i < (1 << c_NLOG2) + 20; i++) begin
            if (!busy2) break;
            nb2++;
            @(negedge clk);
        end
        chk("big_busylen", nb2, (1 << c_NLOG2) + 3);
        chk("big_valid", valid2, 1);
        e2 = model_edges(2, ps2, c_NLOG2);
        chk("big_cnt", cnt2, e2);
        chk("big_range", (cnt2 == 16'h1249 || cnt2 == 16'h124A) ? 1 : 0, 1);
        chk("big_ovf", ovf2, 0);
        sel2 = 1'b0;
        #1 chk("big_lo", data2, e2 & 8'hFF);
        sel2 = 1'b1;
        #1 chk("big_hi", data2, (e2 >> 8) & 8'hFF);
        big_done = 1'b1;
    end

    initial begin : main
        int ps, wait_cnt, e;
        rst0 = 1'b0; rst1 = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        sel0 = 1'b0; sel1 = 1'b0;
        mode0 = 0; per0 = 8;

        repeat (2) @(negedge clk);
        chk_zero(0, "rst0");
        chk_zero(1, "rst1");
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero(0, "idle0");

        // Period-8 square wave, default parameters.
        mode0 = 2; per0 = 8;
        repeat (10) @(negedge clk);
        kick(0);
        ps = ps_last;
        wait_done(0, c_NLOG0, "p8");
        chk_result(0, ps, c_NLOG0, c_W0, "p8");
        chk("p8_range", (cnt0 == 16'd128 || cnt0 == 16'd129) ? 1 : 0, 1);
        e = model_edges(0, ps, c_NLOG0);
        sel0 = 1'b0;
        #1 chk("p8_lo", data0, e & 8'hFF);
        sel0 = 1'b1;
        #1 chk("p8_hi", data0, (e >> 8) & 8'hFF);

        // Constant inputs: no edges inside the window.
        mode0 = 0;
        repeat (10) @(negedge clk);
        kick(0);
        wait_done(0, c_NLOG0, "lo");
        chk("lo_cnt", cnt0, 0);
        chk("lo_ovf", ovf0, 0);
        mode0 = 1;
        repeat (10) @(negedge clk);
        kick(0);
        wait_done(0, c_NLOG0, "hi");
        chk("hi_cnt", cnt0, 0);
        chk("hi_ovf", ovf0, 0);

        // Start held high across two back-to-back measurements, period 16.
        mode0 = 2; per0 = 16;
        repeat (10) @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ps = cyc - 1;
        wait_done(0, c_NLOG0, "hold1");
        chk_result(0, ps, c_NLOG0, c_W0, "hold1");
        chk("hold1_range", (cnt0 == 16'd64 || cnt0 == 16'd65) ? 1 : 0, 1);
        @(negedge clk);
        chk("rearm_valid", valid0, 0);
        chk("rearm_busy", busy0, 1);
        wait_done(0, c_NLOG0, "hold2");
        start0 = 1'b0;
        chk_result(0, ps + (1 << c_NLOG0) + 4, c_NLOG0, c_W0, "hold2");
        chk("hold2_range", (cnt0 == 16'd64 || cnt0 == 16'd65) ? 1 : 0, 1);

        // Asynchronous reset in the middle of the gate window.
        per0 = 8;
        repeat (5) @(negedge clk);
        kick(0);
        repeat (500) @(negedge clk);
        #2 rst0 = 1'b0;
        #1 chk_zero(0, "midrst");
        @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        chk_zero(0, "postrst");
        kick(0);
        ps = ps_last;
        wait_done(0, c_NLOG0, "fresh");
        chk_result(0, ps, c_NLOG0, c_W0, "fresh");
        chk("fresh_range", (cnt0 == 16'd128 || cnt0 == 16'd129) ? 1 : 0, 1);

        // Random-duty ring waveform compared against the history model.
        mode0 = 3;
        for (int k = 0; k < 3; k++) begin
            repeat (int'($urandom_range(5, 30))) @(negedge clk);
            kick(0);
            ps = ps_last;
            wait_done(0, c_NLOG0, "rnd");
            chk_result(0, ps, c_NLOG0, c_W0, "rnd");
            e = model_edges(0, ps, c_NLOG0);
            sel0 = $urandom_range(0, 1) != 0;
            #1 chk("rnd_data", data0, sel0 ? ((e >> 8) & 8'hFF) : (e & 8'hFF));
        end

        // 8-bit counter saturation with a period-4 input.
        repeat (5) @(negedge clk);
        kick(1);
        ps = ps_last;
        wait_done(1, c_NLOG1, "sat");
        chk_result(1, ps, c_NLOG1, c_W1, "sat");
        chk("sat_cnt255", cnt1, 255);
        chk("sat_ovf1", ovf1, 1);

        wait_cnt = 0;
        while (!big_done && wait_cnt < 80000) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("big_finished", big_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
